// File: rtl/mpeg_bs_pkg.sv
// Shared parameters for the MPEG bitstream window and the VLC decoders.
// Optional feature macro: BYTE_ALIGN_EN (byte-align drop port).
package mpeg_bs_pkg;

    localparam int WORD_W  = 32;
    localparam int WIN_W   = 20;
    localparam int BUF_W   = 64;
    localparam int SHIFT_W = 5;
    localparam int CNT_W   = 7;
    localparam int AMT_W   = 6;

endpackage

// File: rtl/mpeg_barrel_shl.sv
// Combinational 64-bit logarithmic left shifter, zero fill.
// Optional feature macro: BYTE_ALIGN_EN (not used here).
module mpeg_barrel_shl
    import mpeg_bs_pkg::*;
(
    input  logic [BUF_W-1:0] data,
    input  logic [AMT_W-1:0] amt,
    output logic [BUF_W-1:0] result
);

    logic [BUF_W-1:0] stage;

    always_comb begin
        stage = data;
        for (int i = 0; i < AMT_W; i++) begin
            if (amt[i]) begin
                stage = stage << (1 << i);
            end
        end
        result = stage;
    end

endmodule

// File: rtl/mpeg_bit_window.sv
// 64-bit bit reservoir presenting a 20-bit MSB-first lookahead window.
// Optional feature macro: BYTE_ALIGN_EN adds align input and bit_pos output.
module mpeg_bit_window
    import mpeg_bs_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [WORD_W-1:0]  in_word,
    input  logic               in_valid,
    output logic               in_ready,
    // window port; "buf" is a reserved gate keyword
    output logic [WIN_W-1:0]   win_buf,
    output logic               win_valid,
    input  logic [SHIFT_W-1:0] shift_amt,
    input  logic               shift_valid,
    input  logic               flush,
    output logic [CNT_W-1:0]   bit_count,
`ifdef BYTE_ALIGN_EN
    input  logic               align,
    output logic [2:0]         bit_pos,
`endif
    output logic               err
);

    logic [BUF_W-1:0] res_q, res_d, res_sh, word_pos;
    logic [CNT_W-1:0] count_q, count_d, cnt_sh;
    logic             err_q, err_d;
    logic             in_ready_q, in_ready_d;
    logic             win_valid_q, win_valid_d;
    logic [AMT_W-1:0] amt, ld_amt;
    logic             shift_ok, bad, load;

`ifdef BYTE_ALIGN_EN
    logic [2:0] bit_pos_q, bit_pos_d, align_amt;
    logic       align_ok;

    always_comb begin
        align_amt = 3'd0 - bit_pos_q;
        shift_ok  = shift_valid & ~align & win_valid_q
                  & (shift_amt <= SHIFT_W'(WIN_W));
        align_ok  = align & ~shift_valid & win_valid_q;
        bad       = (shift_valid & ~shift_ok) | (align & ~align_ok);
        amt       = '0;
        if (shift_ok) begin
            amt = {1'b0, shift_amt};
        end else if (align_ok) begin
            amt = {3'b0, align_amt};
        end
        bit_pos_d = flush ? 3'd0 : bit_pos_q + amt[2:0];
    end
`else
    always_comb begin
        shift_ok = shift_valid & win_valid_q
                 & (shift_amt <= SHIFT_W'(WIN_W));
        bad      = shift_valid & ~shift_ok;
        amt      = shift_ok ? {1'b0, shift_amt} : '0;
    end
`endif

    mpeg_barrel_shl u_consume (
        .data   (res_q),
        .amt    (amt),
        .result (res_sh)
    );

    // incoming word lands just below the post-shift bits
    assign cnt_sh = count_q - CNT_W'(amt);
    assign ld_amt = AMT_W'(CNT_W'(WORD_W) - cnt_sh);
    assign load   = in_valid & in_ready_q;

    mpeg_barrel_shl u_place (
        .data   ({{(BUF_W-WORD_W){1'b0}}, in_word}),
        .amt    (ld_amt),
        .result (word_pos)
    );

    always_comb begin
        res_d   = '0;
        count_d = '0;
        err_d   = 1'b0;
        if (!flush) begin
            res_d   = res_sh | (load ? word_pos : '0);
            count_d = cnt_sh + (load ? CNT_W'(WORD_W) : '0);
            err_d   = err_q | bad;
        end
        in_ready_d  = count_d <= CNT_W'(WORD_W);
        win_valid_d = count_d >= CNT_W'(WIN_W);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_q       <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            win_valid_q <= 1'b0;
        end else begin
            res_q       <= res_d;
            count_q     <= count_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            win_valid_q <= win_valid_d;
        end
    end

`ifdef BYTE_ALIGN_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_pos_q <= '0;
        end else begin
            bit_pos_q <= bit_pos_d;
        end
    end

    assign bit_pos = bit_pos_q;
`endif

    assign win_buf   = res_q[BUF_W-1 -: WIN_W];
    assign win_valid = win_valid_q;
    assign bit_count = count_q;
    assign in_ready  = in_ready_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mpeg_bit_window.sv
// Directed scoreboard bench for mpeg_bit_window.
// Optional feature macro: BYTE_ALIGN_EN enables the align steps.
module tb_mpeg_bit_window;

    typedef struct packed {
        logic [19:0] bufv;
        logic [6:0]  cnt;
        logic        wv;
        logic        er;
        logic        rdy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_word = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] win_buf;
    logic        win_valid;
    logic [4:0]  shift_amt = '0;
    logic        shift_valid = 1'b0;
    logic        flush = 1'b0;
    logic [6:0]  bit_count;
    logic        err;
    logic        align = 1'b0;
`ifdef BYTE_ALIGN_EN
    logic [2:0]  bit_pos;
`endif

    int total = 0;
    int bad = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    mpeg_bit_window dut (
        .clk         (clk),
        .rst         (rst),
        .in_word     (in_word),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .win_buf     (win_buf),
        .win_valid   (win_valid),
        .shift_amt   (shift_amt),
        .shift_valid (shift_valid),
        .flush       (flush),
        .bit_count   (bit_count),
`ifdef BYTE_ALIGN_EN
        .align       (align),
        .bit_pos     (bit_pos),
`endif
        .err         (err)
    );

    function automatic exp_t mk(input logic [19:0] b, input int c,
                                input logic v, input logic e,
                                input logic r);
        exp_t x;
        x.bufv = b;
        x.cnt  = 7'(c);
        x.wv   = v;
        x.er   = e;
        x.rdy  = r;
        return x;
    endfunction

    task automatic check(input string tag);
        exp_t exp, obs;
        obs = {win_buf, bit_count, win_valid, err, in_ready};
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
        end else begin
            exp = sb_q.pop_front();
            assert (obs === exp) else begin
                bad++;
                $error("FAIL %s: buf/cnt/wv/err/rdy observed %h/%0d/%b/%b/%b expected %h/%0d/%b/%b/%b",
                       tag, obs.bufv, obs.cnt, obs.wv, obs.er, obs.rdy,
                       exp.bufv, exp.cnt, exp.wv, exp.er, exp.rdy);
            end
        end
    endtask

    task automatic step(input logic [31:0] w, input logic wv,
                        input int sa, input logic sv,
                        input logic fl, input logic al,
                        input exp_t e, input string tag);
        in_word     = w;
        in_valid    = wv;
        shift_amt   = 5'(sa);
        shift_valid = sv;
        flush       = fl;
        align       = al;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        shift_valid = 1'b0;
        flush       = 1'b0;
        align       = 1'b0;
        check(tag);
    endtask

    initial begin
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        sb_q.push_back(mk(20'h0, 0, 0, 0, 0));
        check("reset");
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 0, mk(20'h0, 0, 0, 0, 1), "ready_after_rst");

        step(32'hFFFF_0000, 1, 0, 0, 0, 0, mk(20'hFFFF0, 32, 1, 0, 1), "t1_load");
        step(0, 0, 3, 1, 0, 0, mk(20'hFFF80, 29, 1, 0, 1), "t2_shift3");
        step(0, 0, 0, 1, 0, 0, mk(20'hFFF80, 29, 1, 0, 1), "t2_shift0");

        step(0, 0, 0, 0, 1, 0, mk(20'h0, 0, 0, 0, 1), "flush_a");
        step(32'hFFFF_0000, 1, 0, 0, 0, 0, mk(20'hFFFF0, 32, 1, 0, 1), "t3_load");
        step(32'h1234_5678, 1, 12, 1, 0, 0, mk(20'hF0000, 52, 1, 0, 0), "t3_shift_load");
        step(0, 0, 20, 1, 0, 0, mk(20'h12345, 32, 1, 0, 1), "t3_boundary");
        step(0, 0, 4, 1, 0, 0, mk(20'h23456, 28, 1, 0, 1), "t3_shift4a");
        step(0, 0, 4, 1, 0, 0, mk(20'h34567, 24, 1, 0, 1), "t3_shift4b");

        step(0, 0, 21, 1, 0, 0, mk(20'h34567, 24, 1, 1, 1), "t4_shift21");
        step(0, 0, 14, 1, 0, 0, mk(20'h9E000, 10, 0, 1, 1), "t4_underflow_buf");
        step(0, 0, 5, 1, 0, 0, mk(20'h9E000, 10, 0, 1, 1), "t4_shift_novalid");

        step(0, 0, 0, 0, 1, 0, mk(20'h0, 0, 0, 0, 1), "t5_flush_clr_err");
        step(32'hAAAA_5555, 1, 0, 0, 0, 0, mk(20'hAAAA5, 32, 1, 0, 1), "t5_load1");
        step(32'h0F0F_0F0F, 1, 0, 0, 0, 0, mk(20'hAAAA5, 64, 1, 0, 0), "t5_full");
        step(32'hDEAD_BEEF, 1, 25, 1, 0, 0, mk(20'hAAAA5, 64, 1, 1, 0), "t5_full_badshift");
        step(0, 0, 20, 1, 0, 0, mk(20'h5550F, 44, 1, 1, 0), "t5_drain1");
        step(0, 0, 20, 1, 0, 0, mk(20'h0F0F0, 24, 1, 1, 1), "t5_drain2");
        step(32'h1234_5678, 1, 0, 0, 1, 0, mk(20'h0, 0, 0, 0, 1), "t5_flush_load");
        step(0, 0, 0, 0, 0, 0, mk(20'h0, 0, 0, 0, 1), "t5_word_dropped");

        step(32'hFFFF_0000, 1, 0, 0, 0, 0, mk(20'hFFFF0, 32, 1, 0, 1), "rst_preload");
        rst = 1'b0;
        #1;
        sb_q.push_back(mk(20'h0, 0, 0, 0, 0));
        check("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 0, mk(20'h0, 0, 0, 0, 1), "rst_release");

`ifdef BYTE_ALIGN_EN
        step(32'h1234_5678, 1, 0, 0, 0, 0, mk(20'h12345, 32, 1, 0, 1), "t6_load");
        step(0, 0, 3, 1, 0, 0, mk(20'h91A2B, 29, 1, 0, 1), "t6_shift3");
        step(0, 0, 0, 0, 0, 1, mk(20'h34567, 24, 1, 0, 1), "t6_align");
        step(0, 0, 0, 0, 0, 1, mk(20'h34567, 24, 1, 0, 1), "t6_align_noop");
        step(0, 0, 4, 1, 0, 1, mk(20'h34567, 24, 1, 1, 1), "t6_align_shift");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
